// File: rtl/capture_pkg.sv
// Shared types and default widths for the triggered sample capture block.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

   localparam int DEF_A_WIDTH     = 8;
   localparam int DEF_D_WIDTH     = 8;
   localparam int DEF_PRE_SAMPLES = 64;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read.
// A read and a write to the same address in one cycle returns the old data.
module capture_ram #(
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [A_WIDTH-1:0] waddr,
   input  logic [D_WIDTH-1:0] wdata,
   input  logic [A_WIDTH-1:0] raddr,
   output logic [D_WIDTH-1:0] rdata
);

   logic [D_WIDTH-1:0] mem [2**A_WIDTH];

   // Write port; storage is never cleared by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read; non-blocking update gives old data on collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sample_capture.sv
// Triggered capture buffer for the sine generator sample stream.
// Arm, wait for a rising crossing of trig_level, then record a window of
// DEPTH samples into RAM. Optional feature macro: PRE_TRIGGER_EN keeps
// PRE_SAMPLES samples from before the trigger in a ring.
module sample_capture
   import capture_pkg::*;
#(
   parameter int A_WIDTH     = DEF_A_WIDTH,
   parameter int D_WIDTH     = DEF_D_WIDTH,
   parameter int PRE_SAMPLES = DEF_PRE_SAMPLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [D_WIDTH-1:0] din,
   input  logic [D_WIDTH-1:0] trig_level,
   input  logic               arm,
   input  logic [A_WIDTH-1:0] rd_addr,
   output logic [D_WIDTH-1:0] rd_data,
   output logic               armed,
   output logic               capturing,
   output logic               done,
   output logic [A_WIDTH-1:0] trig_addr
);

   localparam int DEPTH = 2**A_WIDTH;
`ifdef PRE_TRIGGER_EN
   localparam int POST = DEPTH - PRE_SAMPLES - 1;
`else
   localparam int POST = DEPTH - 1;
`endif
   // Offset from the trigger address to the last address of the window.
   localparam logic [A_WIDTH-1:0] LAST_OFS = A_WIDTH'(POST);

   // Elaboration-time guard on the pre-trigger depth.
   if (PRE_SAMPLES < 1 || PRE_SAMPLES > DEPTH - 1) begin : g_bad_pre
      $error("sample_capture: PRE_SAMPLES out of range 1..DEPTH-1");
   end

   cap_state_t         state, next_state;
   logic [A_WIDTH-1:0] wr_ptr;
   logic [D_WIDTH-1:0] prev;
   logic               prev_valid;
   logic               trigger;
   logic               we;
   logic [A_WIDTH-1:0] waddr;
   logic               enter_armed;

`ifdef PRE_TRIGGER_EN
   logic [A_WIDTH-1:0] fill;
   logic [A_WIDTH-1:0] trig_addr_q;
   logic               fill_full;
   assign fill_full = (fill == A_WIDTH'(PRE_SAMPLES));
   assign trig_addr = trig_addr_q;
`else
   assign trig_addr = '0;
`endif

   assign armed       = (state == ARMED);
   assign capturing   = (state == CAPTURE);
   assign done        = (state == DONE);
   assign enter_armed = (state != ARMED) && (next_state == ARMED);

   // Next-state, trigger detect and RAM write control.
   always_comb begin
      next_state = state;
      we         = 1'b0;
      waddr      = wr_ptr;
      trigger    = prev_valid && (prev < trig_level) && (din >= trig_level);
`ifdef PRE_TRIGGER_EN
      trigger    = trigger && fill_full;
`endif
      case (state)
         IDLE: begin
            if (arm) next_state = ARMED;
         end
         ARMED: begin
            if (en) begin
`ifdef PRE_TRIGGER_EN
               we = 1'b1;
`endif
               if (trigger) begin
                  we = 1'b1;
`ifndef PRE_TRIGGER_EN
                  waddr = '0;
`endif
                  next_state = (POST == 0) ? DONE : CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (en) begin
               we = 1'b1;
               if (wr_ptr == trig_addr + LAST_OFS) next_state = DONE;
            end
         end
         DONE: begin
            if (arm) next_state = ARMED;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Write pointer, previous-sample tracking and pre-trigger bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
`ifdef PRE_TRIGGER_EN
         fill        <= '0;
         trig_addr_q <= '0;
`endif
      end else if (enter_armed) begin
         wr_ptr     <= '0;
         prev_valid <= 1'b0;
`ifdef PRE_TRIGGER_EN
         fill       <= '0;
`endif
      end else if (en) begin
         if (state == ARMED) begin
            prev       <= din;
            prev_valid <= 1'b1;
            if (we) wr_ptr <= waddr + A_WIDTH'(1);
`ifdef PRE_TRIGGER_EN
            if (!fill_full) fill <= fill + A_WIDTH'(1);
            if (trigger) trig_addr_q <= wr_ptr;
`endif
         end else if (state == CAPTURE) begin
            wr_ptr <= wr_ptr + A_WIDTH'(1);
         end
      end
   end

   capture_ram #(
      .A_WIDTH (A_WIDTH),
      .D_WIDTH (D_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with A_WIDTH=4 (DEPTH=16), PRE_SAMPLES=4.
module tb_sample_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] din;
   logic [7:0] trig_level;
   logic       arm;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       armed, capturing, done;
   logic [3:0] trig_addr;

   int n_checks = 0;
   int n_fail   = 0;

   // flag encoding used in checks: {armed, capturing, done}
   localparam logic [2:0] F_NONE = 3'b000;
   localparam logic [2:0] F_ARM  = 3'b100;
   localparam logic [2:0] F_CAP  = 3'b010;
   localparam logic [2:0] F_DONE = 3'b001;

   sample_capture #(
      .A_WIDTH     (4),
      .D_WIDTH     (8),
      .PRE_SAMPLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .din        (din),
      .trig_level (trig_level),
      .arm        (arm),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .armed      (armed),
      .capturing  (capturing),
      .done       (done),
      .trig_addr  (trig_addr)
   );

   always #5 clk = ~clk;

   // One clock: drive inputs, take the edge, settle #1 after it.
   task automatic step(input logic s_en, input logic [7:0] s_din, input logic s_arm);
      en  = s_en;
      din = s_din;
      arm = s_arm;
      @(posedge clk);
      #1;
      arm = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef PRE_TRIGGER_EN
   logic [7:0] model_mem [16];
`endif

   initial begin
      rst = 1'b1; en = 1'b0; din = '0; trig_level = '0; arm = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags", {armed, capturing, done}, F_NONE);
      check("reset_trig_addr", trig_addr, 4'd0);
      check("reset_rd_data", rd_data, 8'd0);
      rst = 1'b0;

`ifndef PRE_TRIGGER_EN
      // Ramp trigger at level 5
      trig_level = 8'd5;
      step(1'b0, 8'd0, 1'b1);
      check("ramp_armed", {armed, capturing, done}, F_ARM);
      for (int d = 0; d < 5; d++) step(1'b1, 8'(d), 1'b0);
      check("ramp_pre_trigger", {armed, capturing, done}, F_ARM);
      step(1'b1, 8'd5, 1'b0);
      check("ramp_trigger", {armed, capturing, done}, F_CAP);
      // arm pulse mid-capture must be ignored
      for (int d = 6; d < 20; d++) step(1'b1, 8'(d), d == 10);
      check("ramp_capture_arm_ignored", {armed, capturing, done}, F_CAP);
      step(1'b1, 8'd20, 1'b0);
      check("ramp_done", {armed, capturing, done}, F_DONE);
      check("ramp_trig_addr", trig_addr, 4'd0);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         step(1'b0, 8'd0, 1'b0);
         check($sformatf("ramp_ram[%0d]", i), rd_data, 32'(5 + i));
      end

      // Re-arm from DONE
      step(1'b0, 8'd0, 1'b1);
      check("rearm", {armed, capturing, done}, F_ARM);

      // Held level above threshold never triggers
      trig_level = 8'd100;
      for (int k = 0; k < 50; k++) step(1'b1, 8'd200, 1'b0);
      check("held_high_no_trig", {armed, capturing, done}, F_ARM);
      step(1'b1, 8'd50, 1'b0);
      check("low_sample_no_trig", {armed, capturing, done}, F_ARM);
      rd_addr = 4'd1;
      step(1'b1, 8'd150, 1'b0);
      check("cross_trigger", {armed, capturing, done}, F_CAP);
      // write and read addr 1 together: old data (6) comes back
      step(1'b1, 8'd151, 1'b0);
      check("collision_old_data", rd_data, 8'd6);
      step(1'b0, 8'hEE, 1'b0);
      check("after_collision", rd_data, 8'd151);
      // en toggling; en=0 cycles carry junk that must never be written
      for (int k = 2; k < 15; k++) begin
         step(1'b0, 8'hEE, 1'b0);
         step(1'b1, 8'(150 + k), 1'b0);
      end
      check("gated_capture_15", {armed, capturing, done}, F_CAP);
      step(1'b0, 8'hEE, 1'b0);
      check("gated_idle_cycle", {armed, capturing, done}, F_CAP);
      step(1'b1, 8'd165, 1'b0);
      check("gated_done", {armed, capturing, done}, F_DONE);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         step(1'b0, 8'd0, 1'b0);
         check($sformatf("gated_ram[%0d]", i), rd_data, 32'(150 + i));
      end

      // Reset in the middle of a capture
      trig_level = 8'd5;
      step(1'b0, 8'd0, 1'b1);
      for (int d = 0; d < 8; d++) step(1'b1, 8'(d), 1'b0);
      check("mid_capture", {armed, capturing, done}, F_CAP);
      rst = 1'b1;
      step(1'b1, 8'd8, 1'b0);
      step(1'b1, 8'd9, 1'b0);
      check("midrst_flags", {armed, capturing, done}, F_NONE);
      check("midrst_trig_addr", trig_addr, 4'd0);
      check("midrst_rd_data", rd_data, 8'd0);
      rst = 1'b0;
      step(1'b0, 8'd0, 1'b1);
      check("midrst_rearm", {armed, capturing, done}, F_ARM);
`else
      // Pre-trigger: sawtooth 0..9, level 2, trigger deferred until fill=4
      trig_level = 8'd2;
      step(1'b0, 8'd0, 1'b1);
      check("pre_armed", {armed, capturing, done}, F_ARM);
      for (int n = 0; n < 24; n++) begin
         step(1'b1, 8'(n % 10), 1'b0);
         model_mem[n % 16] = 8'(n % 10);
         if (n == 2)  check("pre_early_crossing_ignored", {armed, capturing, done}, F_ARM);
         if (n == 11) check("pre_before_trig", {armed, capturing, done}, F_ARM);
         if (n == 12) begin
            check("pre_trigger", {armed, capturing, done}, F_CAP);
            check("pre_trig_addr", trig_addr, 4'd12);
         end
         if (n == 22) check("pre_capture_last", {armed, capturing, done}, F_CAP);
      end
      check("pre_done", {armed, capturing, done}, F_DONE);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'((12 - 4 + i) % 16);
         step(1'b0, 8'd0, 1'b0);
         check($sformatf("pre_window[%0d]", i), rd_data, model_mem[(12 - 4 + i) % 16]);
      end
      step(1'b0, 8'd0, 1'b1);
      check("pre_rearm", {armed, capturing, done}, F_ARM);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
